// File: rtl/arith_pkg.sv
// arith_pkg
//   Shared definitions for the bit-serial arithmetic blocks.
//   WIDTH_DEFAULT : default operand width
//   sub_state_t   : serial subtractor sequencing states
//   cnt_width()   : bit-counter width for a given operand width
package arith_pkg;

    localparam int WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    // WIDTH is at least 2, so $clog2 never returns 0 here.
    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/FullSubtractor.sv
// FullSubtractor
//   Combinational 1-bit full-subtractor cell: d = a - b - brIn.
//   a, b  : operand bits
//   brIn  : borrow in
//   d     : difference bit
//   brOut : borrow out
module FullSubtractor (
    input  logic a,
    input  logic b,
    input  logic brIn,
    output logic d,
    output logic brOut
);

    assign d     = a ^ b ^ brIn;
    assign brOut = (~a & b) | (~(a ^ b) & brIn);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial two's-complement subtractor, in1 - in2 - bIn, LSB first,
//   one bit per clock, with a start/busy/done handshake.
//   clk, rstN       : clock, synchronous active-low reset
//   start           : request; operands sampled on the accepting edge
//   in1, in2, bIn   : minuend, subtrahend, borrow-in
//   busy            : subtraction in progress
//   done            : one-cycle pulse, results valid
//   diff            : in1 - in2 - bIn mod 2^WIDTH
//   bOut, ovf, zero : final borrow, signed overflow, diff == 0
//
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | shifting one bit per edge through the subtractor cell
//   DONE  | results valid, done pulse; start accepted back-to-back
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             bIn,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bOut,
    output logic             ovf,
    output logic             zero
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    sub_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             br_q, br_d;
    // Operand MSBs are kept aside because A and B are shifted away.
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             fs_d;
    logic             fs_br;
    logic [WIDTH-1:0] diff_shift;

    FullSubtractor u_fs (
        .a     (a_q[0]),
        .b     (b_q[0]),
        .brIn  (br_q),
        .d     (fs_d),
        .brOut (fs_br)
    );

    assign diff_shift = {fs_d, diff_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        br_d    = br_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = in1;
                    b_d     = in2;
                    br_d    = bIn;
                    a_msb_d = in1[WIDTH-1];
                    b_msb_d = in2[WIDTH-1];
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                diff_d = diff_shift;
                br_d   = fs_br;
                a_d    = {1'b0, a_q[WIDTH-1:1]};
                b_d    = {1'b0, b_q[WIDTH-1:1]};
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    bout_d  = fs_br;
                    // fs_d is the result MSB on this final edge.
                    ovf_d   = (a_msb_q ^ b_msb_q) & (fs_d ^ a_msb_q);
                    zero_d  = (diff_shift == '0);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bOut = bout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;

endmodule
